// File: rtl/sram_responder.sv
// sram_responder: target-side model of the CPU's simple SRAM interface.
//
// Serves the instruction port and the data port from one shared word RAM,
// with single-cycle registered reads (read-before-write on collisions), and
// decodes a 64-byte MMIO window on the data port:
//   0x00 LED (RW, 16 bits)       0x04 SWITCH (RO, 2-flop synchronized)
//   0x08 TIMER (RW, 32 bits)     0x0C UART_DATA (WO, pushes TX FIFO)
//   0x10 UART_STATUS (RO {overflow, full, empty}; any write clears overflow)
//
// Optional feature macro: SRAM_RESP_TIMER_EN
//   defined   -> free-running TIMER register at offset 0x08
//   undefined -> no timer flops; offset 0x08 reads 0, writes ignored
//
// Ports:
//   clk, reset                  clock; synchronous active-high reset
//   inst_sram_we/addr/wdata     instruction port (we and wdata ignored)
//   inst_sram_rdata             instruction read data, 1 cycle after addr
//   data_sram_we/addr/wdata     data port, full-word writes
//   data_sram_rdata             data read data, 1 cycle after addr
//   led                         LED register
//   switch                      asynchronous switch inputs
//   uart_tx_data/valid/ready    UART TX FIFO head, pop on valid & ready
module sram_responder #(
    parameter logic [31:0] RAM_BASE        = 32'h1c000000,
    parameter int unsigned RAM_AW          = 14,
    parameter logic [31:0] MMIO_BASE       = 32'hbfaf0000,
    parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_we,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [15:0] led,
    input  logic [7:0]  switch,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready
);

    localparam int unsigned RAM_WORDS  = 1 << RAM_AW;
    localparam int unsigned FIFO_DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int unsigned PW         = FIFO_DEPTH_LOG2 + 1;

    localparam logic [3:0] REG_LED    = 4'd0;
    localparam logic [3:0] REG_SWITCH = 4'd1;
    localparam logic [3:0] REG_TIMER  = 4'd2;
    localparam logic [3:0] REG_UART   = 4'd3;
    localparam logic [3:0] REG_STATUS = 4'd4;

    // ------------------------------------------------------------------
    // Address decode: subtract the base, then the window is hit when all
    // offset bits above the window size are zero.
    // ------------------------------------------------------------------
    logic [31:0]        i_off, d_off, m_off;
    logic               i_ram_hit, d_ram_hit, d_mmio_hit;
    logic [RAM_AW-1:0]  i_idx, d_idx;
    logic [3:0]         m_reg;

    assign i_off      = inst_sram_addr - RAM_BASE;
    assign d_off      = data_sram_addr - RAM_BASE;
    assign m_off      = data_sram_addr - MMIO_BASE;
    assign i_ram_hit  = (i_off[31:RAM_AW+2] == '0);
    assign d_ram_hit  = (d_off[31:RAM_AW+2] == '0);
    assign d_mmio_hit = (m_off[31:6] == '0);
    assign i_idx      = i_off[RAM_AW+1:2];
    assign d_idx      = d_off[RAM_AW+1:2];
    assign m_reg      = m_off[5:2];

    logic wr_mmio, wr_led, wr_uart, wr_status;
    assign wr_mmio   = data_sram_we && d_mmio_hit && !d_ram_hit;
    assign wr_led    = wr_mmio && (m_reg == REG_LED);
    assign wr_uart   = wr_mmio && (m_reg == REG_UART);
    assign wr_status = wr_mmio && (m_reg == REG_STATUS);

    logic unused_bits;
    assign unused_bits = ^{inst_sram_we, inst_sram_wdata, i_off[1:0], d_off[1:0], m_off[1:0]};

    // ------------------------------------------------------------------
    // Shared word RAM (not reset). Nonblocking write gives read-before-write.
    // ------------------------------------------------------------------
    logic [31:0] mem [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (data_sram_we && d_ram_hit) begin
            mem[d_idx] <= data_sram_wdata;
        end
    end

    // ------------------------------------------------------------------
    // MMIO state
    // ------------------------------------------------------------------
    logic [15:0] led_q;
    logic [7:0]  sw_meta_q, sw_sync_q;
    logic [31:0] timer_rd;

`ifdef SRAM_RESP_TIMER_EN
    logic        wr_timer;
    logic [31:0] timer_q;

    assign wr_timer = wr_mmio && (m_reg == REG_TIMER);
    assign timer_rd = timer_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= '0;
        end else if (wr_timer) begin
            timer_q <= data_sram_wdata;
        end else begin
            timer_q <= timer_q + 32'd1;
        end
    end
`else
    assign timer_rd = '0;
`endif

    // ------------------------------------------------------------------
    // UART TX FIFO: pointers one bit wider than the index; full when the
    // indices match and the wrap bits differ.
    // ------------------------------------------------------------------
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic          ovf_q;
    logic          fifo_empty, fifo_full, fifo_pop, fifo_push;

    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q == {~rptr_q[PW-1], rptr_q[PW-2:0]});
    assign fifo_pop   = !fifo_empty && uart_tx_ready;
    // A concurrent pop frees the slot, so a push into a full FIFO still lands.
    assign fifo_push  = wr_uart && (!fifo_full || fifo_pop);

    always_ff @(posedge clk) begin
        if (!reset && fifo_push) begin
            fifo_mem[wptr_q[PW-2:0]] <= data_sram_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (fifo_push) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (fifo_pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
            if (wr_status) begin
                ovf_q <= 1'b0;
            end else if (wr_uart && !fifo_push) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign uart_tx_data  = fifo_mem[rptr_q[PW-2:0]];
    assign uart_tx_valid = !fifo_empty;

    // ------------------------------------------------------------------
    // Read muxes and registered read data
    // ------------------------------------------------------------------
    logic [31:0] inst_rdata_d, data_rdata_d;
    logic [31:0] inst_rdata_q, data_rdata_q;

    always_comb begin
        inst_rdata_d = '0;
        if (i_ram_hit) begin
            inst_rdata_d = mem[i_idx];
        end
    end

    always_comb begin
        data_rdata_d = '0;
        if (d_ram_hit) begin
            data_rdata_d = mem[d_idx];
        end else if (d_mmio_hit) begin
            case (m_reg)
                REG_LED:    data_rdata_d = {16'b0, led_q};
                REG_SWITCH: data_rdata_d = {24'b0, sw_sync_q};
                REG_TIMER:  data_rdata_d = timer_rd;
                REG_STATUS: data_rdata_d = {29'b0, ovf_q, fifo_full, fifo_empty};
                default:    data_rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            led_q        <= '0;
            sw_meta_q    <= '0;
            sw_sync_q    <= '0;
        end else begin
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            sw_meta_q    <= switch;
            sw_sync_q    <= sw_meta_q;
            if (wr_led) begin
                led_q <= data_sram_wdata[15:0];
            end
        end
    end

    assign inst_sram_rdata = inst_rdata_q;
    assign data_sram_rdata = data_rdata_q;
    assign led             = led_q;

endmodule

// File: tb/tb_sram_responder.sv
module tb_sram_responder;

    localparam logic [31:0] RAM_BASE  = 32'h1c000000;
    localparam logic [31:0] RAM_BYTES = 32'h00010000;
    localparam logic [31:0] MMIO_BASE = 32'hbfaf0000;
    localparam int          FIFO_CAP  = 4;

    localparam logic [31:0] A_LED    = MMIO_BASE + 32'h00;
    localparam logic [31:0] A_SW     = MMIO_BASE + 32'h04;
    localparam logic [31:0] A_TIMER  = MMIO_BASE + 32'h08;
    localparam logic [31:0] A_UART   = MMIO_BASE + 32'h0C;
    localparam logic [31:0] A_STATUS = MMIO_BASE + 32'h10;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_we;
    logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
    logic        data_sram_we;
    logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
    logic [15:0] led;
    logic [7:0]  switch;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid, uart_tx_ready;

    always #5 clk = ~clk;

    sram_responder #(
        .RAM_BASE(RAM_BASE),
        .RAM_AW(14),
        .MMIO_BASE(MMIO_BASE),
        .FIFO_DEPTH_LOG2(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .inst_sram_we(inst_sram_we),
        .inst_sram_addr(inst_sram_addr),
        .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_we(data_sram_we),
        .data_sram_addr(data_sram_addr),
        .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata),
        .led(led),
        .switch(switch),
        .uart_tx_data(uart_tx_data),
        .uart_tx_valid(uart_tx_valid),
        .uart_tx_ready(uart_tx_ready)
    );

    // Expected observation for one cycle, due at the cycle after issue.
    typedef struct {
        int unsigned due;
        bit          ci;
        logic [31:0] iv;
        bit          cd;
        logic [31:0] dv;
        logic [15:0] led;
        bit          uv;
        logic [7:0]  ud;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc    = 0;
    int unsigned errors = 0;
    int unsigned checks = 0;

    // Reference model state
    logic [31:0] ram_m [int unsigned];
    logic [15:0] led_m;
    logic [7:0]  sw1_m, sw2_m;
    logic [31:0] tmr_m;
    logic [7:0]  fifo_m[$];
    bit          ovf_m;

    // Stimulus for the next cycle
    bit          t_rst;
    logic [31:0] t_ia, t_da, t_wd;
    bit          t_we;
    logic [7:0]  t_sw;
    bit          t_rdy;

    function automatic bit in_ram(input logic [31:0] a);
        return (a >= RAM_BASE) && (a < RAM_BASE + RAM_BYTES);
    endfunction

    function automatic bit in_mmio(input logic [31:0] a);
        return (a >= MMIO_BASE) && (a < MMIO_BASE + 32'd64);
    endfunction

    task automatic step();
        exp_t        e;
        int unsigned w;
        logic [31:0] off;
        reset           = t_rst;
        inst_sram_addr  = t_ia;
        inst_sram_we    = 1'($urandom_range(0, 1));
        inst_sram_wdata = $urandom;
        data_sram_addr  = t_da;
        data_sram_we    = t_we;
        data_sram_wdata = t_wd;
        switch          = t_sw;
        uart_tx_ready   = t_rdy;

        e.due = cyc + 1;
        // Reads: value selected by this cycle's address, state before the edge
        e.ci = 1'b1; e.iv = '0;
        e.cd = 1'b1; e.dv = '0;
        if (!t_rst) begin
            if (in_ram(t_ia)) begin
                w = (t_ia - RAM_BASE) / 4;
                if (ram_m.exists(w)) e.iv = ram_m[w];
                else e.ci = 1'b0;
            end
            if (in_ram(t_da)) begin
                w = (t_da - RAM_BASE) / 4;
                if (ram_m.exists(w)) e.dv = ram_m[w];
                else e.cd = 1'b0;
            end else if (in_mmio(t_da)) begin
                off = (t_da - MMIO_BASE) / 4;
                case (off)
                    0: e.dv = {16'b0, led_m};
                    1: e.dv = {24'b0, sw2_m};
`ifdef SRAM_RESP_TIMER_EN
                    2: e.dv = tmr_m;
`endif
                    4: e.dv = {29'b0, ovf_m, (fifo_m.size() == FIFO_CAP), (fifo_m.size() == 0)};
                    default: e.dv = '0;
                endcase
            end
        end

        // State update at the edge
        if (t_we && in_ram(t_da)) ram_m[(t_da - RAM_BASE) / 4] = t_wd;
        if (t_rst) begin
            led_m = '0; sw1_m = '0; sw2_m = '0; tmr_m = '0;
            fifo_m.delete(); ovf_m = 1'b0;
        end else begin
            off = (t_da - MMIO_BASE) / 4;
            if (fifo_m.size() > 0 && t_rdy) void'(fifo_m.pop_front());
            if (t_we && in_mmio(t_da)) begin
                case (off)
                    0: led_m = t_wd[15:0];
                    3: if (fifo_m.size() < FIFO_CAP) fifo_m.push_back(t_wd[7:0]);
                       else ovf_m = 1'b1;
                    4: ovf_m = 1'b0;
                    default: ;
                endcase
            end
            if (t_we && in_mmio(t_da) && off == 2) tmr_m = t_wd;
            else tmr_m = tmr_m + 32'd1;
            sw2_m = sw1_m;
            sw1_m = t_sw;
        end

        e.led = led_m;
        e.uv  = (fifo_m.size() > 0);
        e.ud  = e.uv ? fifo_m[0] : 8'h00;
        sb.push_back(e);

        @(posedge clk);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        t_da = a; t_we = 1'b1; t_wd = d;
        step();
        t_we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        t_da = a; t_we = 1'b0;
        step();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every registered output against the queued expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due != cyc) check("stale_expectation", cyc, e.due);
            if (e.ci) check("inst_rdata", inst_sram_rdata, e.iv);
            if (e.cd) check("data_rdata", data_sram_rdata, e.dv);
            check("led", {16'b0, led}, {16'b0, e.led});
            check("uart_valid", {31'b0, uart_tx_valid}, {31'b0, e.uv});
            if (e.uv) check("uart_data", {24'b0, uart_tx_data}, {24'b0, e.ud});
        end
    end

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 7))
            0, 1, 2, 3: return RAM_BASE + 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
            4:          return RAM_BASE + RAM_BYTES - 32'($urandom_range(1, 8));
            5, 6:       return MMIO_BASE + 32'($urandom_range(0, 63));
            default:    return $urandom;
        endcase
    endfunction

    initial begin
        t_rst = 1'b1; t_ia = RAM_BASE; t_da = RAM_BASE; t_wd = '0;
        t_we = 1'b0; t_sw = '0; t_rdy = 1'b0;
        led_m = '0; sw1_m = '0; sw2_m = '0; tmr_m = '0; ovf_m = 1'b0;
        repeat (3) step();
        t_rst = 1'b0;

        // RAM write then read on both ports
        wr(32'h1c000010, 32'h12345678);
        t_ia = 32'h1c000010;
        rd(32'h1c000010);

        // Collision: data write vs inst read of the same word
        wr(32'h1c000020, 32'hAAAA0000);
        t_ia = 32'h1c000020;
        wr(32'h1c000020, 32'h5555FFFF);
        rd(32'h1c000020);
        step();

        // LED, SWITCH, inst read of MMIO
        t_ia = MMIO_BASE;
        wr(A_LED, 32'h0001ABCD);
        rd(A_LED);
        t_sw = 8'hA5;
        repeat (4) rd(A_SW);

        // Timer wrap
        wr(A_TIMER, 32'hFFFFFFFE);
        repeat (4) rd(A_TIMER);

        // FIFO fill, overflow, drain, clear
        t_rdy = 1'b0;
        for (int i = 0; i < 5; i++) wr(A_UART, 32'h41 + 32'(i));
        rd(A_STATUS);
        t_rdy = 1'b1;
        repeat (6) rd(A_STATUS);
        wr(A_STATUS, 32'h0);
        rd(A_STATUS);

        // Push with pop when full, then push with ready when empty
        t_rdy = 1'b0;
        for (int i = 0; i < 4; i++) wr(A_UART, 32'h60 + 32'(i));
        t_rdy = 1'b1;
        wr(A_UART, 32'h99);
        repeat (6) rd(A_STATUS);
        wr(A_UART, 32'h77);
        repeat (3) rd(A_STATUS);

        // Reset mid-operation, RAM retained
        t_rdy = 1'b0;
        wr(A_UART, 32'h01);
        wr(A_UART, 32'h02);
        wr(A_LED, 32'h00FF);
        t_rst = 1'b1;
        rd(A_LED);
        t_rst = 1'b0;
        t_ia = 32'h1c000020;
        rd(32'h1c000010);

        // Out-of-window accesses and window edges
        wr(RAM_BASE, 32'hCAFEF00D);
        rd(32'h00000000);
        wr(32'h00000000, 32'hDEADBEEF);
        rd(RAM_BASE);
        wr(RAM_BASE + RAM_BYTES - 4, 32'h0BADF00D);
        wr(RAM_BASE + RAM_BYTES, 32'h11111111);
        rd(RAM_BASE + RAM_BYTES - 4);
        rd(RAM_BASE + RAM_BYTES);
        wr(MMIO_BASE + 32'h3C, 32'h22222222);
        rd(MMIO_BASE + 32'h3C);

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            t_rst = ($urandom_range(0, 199) == 0);
            t_ia  = rand_addr();
            t_da  = rand_addr();
            t_we  = !t_rst && ($urandom_range(0, 2) == 0);
            t_wd  = $urandom;
            if ($urandom_range(0, 15) == 0) t_sw = 8'($urandom);
            t_rdy = ($urandom_range(0, 2) != 0);
            step();
        end
        t_rst = 1'b0; t_we = 1'b0;

        @(negedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
